sbox_table_loader: RTL and testbench

- Writer side for the DES S-box lookup tables: loads all eight 64x4 S-box tables at run time from a byte stream instead of fixed init files.
- Stores the tables in internal RAM and serves the same registered row/col lookup the round datapath already uses: one-cycle read latency, dout zero in reset.
- Sits between the host/config interface and the f-function. Contents are qualified by a trailing XOR checksum byte.

---
 rtl/des_pkg.sv | 20 ++
 rtl/sbox_ram.sv | 54 +++++
 rtl/sbox_table_loader.sv | 147 ++++++++++++++
 tb/tb_sbox_table_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants and loader state encoding for the DES S-box table path.
package des_pkg;

  localparam int SBOX_ENTRIES = 64;
  localparam int SBOX_BYTES   = 32;
  localparam int SBOX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  // Packed-byte address of a table entry: box in the top bits, entry pair below.
  function automatic logic [7:0] sbox_byte_addr(input logic [2:0] box, input logic [5:0] idx);
    return {box, idx[5:1]};
  endfunction

endpackage

// File: rtl/sbox_ram.sv
// Byte-wide S-box storage: synchronous write, registered nibble read with
// read-before-write behaviour and a zeroed output while in reset.
module sbox_ram
  import des_pkg::*;
#(
  parameter int N_BOX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  input  logic       rnib,
  input  logic       rvalid,
  output logic [3:0] dout
);

  localparam int DEPTH = N_BOX * SBOX_BYTES;

  logic [7:0]        mem [0:DEPTH-1];
  logic [7:0]        rd_byte;
  logic [SBOX_W-1:0] dout_d;
  logic [SBOX_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read samples the array before this edge's write lands, giving the old value.
  always_comb begin
    rd_byte = 8'd0;
    dout_d  = 4'd0;
    if (rvalid) begin
      rd_byte = mem[raddr];
      dout_d  = rnib ? rd_byte[7:4] : rd_byte[3:0];
    end else begin
      dout_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 4'd0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sbox_table_loader.sv
// Run-time loader for the eight DES S-box tables: streams packed bytes into RAM,
// qualifies them with a trailing XOR checksum, and serves registered lookups.
module sbox_table_loader
  import des_pkg::*;
#(
  parameter int N_BOX         = 8,
  parameter int BYTES_PER_BOX = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] box_sel,
  input  logic [1:0] row,
  input  logic [3:0] col,
  output logic [3:0] dout,
  output logic       table_valid,
  output logic       load_busy,
  output logic       load_err
);

  localparam logic [7:0] LAST_BYTE = 8'(N_BOX * BYTES_PER_BOX - 1);
  localparam logic [3:0] N_BOX_L   = 4'(N_BOX);

  load_state_e state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic [7:0]  csum_q, csum_d;
  logic        table_valid_q, table_valid_d;
  logic        load_err_q, load_err_d;
  logic        in_ready_q, in_ready_d;
  logic        load_busy_q, load_busy_d;
  logic        accept_s;
  logic        ram_we_s;
  logic        rd_valid_s;

  // load_start always wins over a byte offered in the same cycle.
  assign accept_s = in_valid && in_ready_q && !load_start;

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    csum_d        = csum_q;
    table_valid_d = table_valid_q;
    load_err_d    = load_err_q;
    ram_we_s      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d       = ST_LOAD;
          counter_d     = 8'd0;
          csum_d        = 8'd0;
          table_valid_d = 1'b0;
          load_err_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          counter_d     = 8'd0;
          csum_d        = 8'd0;
          table_valid_d = 1'b0;
          load_err_d    = 1'b0;
        end else if (accept_s) begin
          ram_we_s = 1'b1;
          csum_d   = csum_q ^ in_data;
          if (counter_q == LAST_BYTE) begin
            state_d = ST_CHECK;
          end else begin
            counter_d = counter_q + 8'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (load_start) begin
          state_d       = ST_LOAD;
          counter_d     = 8'd0;
          csum_d        = 8'd0;
          table_valid_d = 1'b0;
          load_err_d    = 1'b0;
        end else if (accept_s) begin
          state_d = ST_DONE;
          if (in_data == csum_q) begin
            table_valid_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        table_valid_d = 1'b0;
        load_err_d    = 1'b0;
      end
    endcase
    in_ready_d  = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    load_busy_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      counter_q     <= 8'd0;
      csum_q        <= 8'd0;
      table_valid_q <= 1'b0;
      load_err_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      load_busy_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      csum_q        <= csum_d;
      table_valid_q <= table_valid_d;
      load_err_q    <= load_err_d;
      in_ready_q    <= in_ready_d;
      load_busy_q   <= load_busy_d;
    end
  end

  assign rd_valid_s = ({1'b0, box_sel} < N_BOX_L);

  sbox_ram #(
    .N_BOX (N_BOX)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we     (ram_we_s && !rst),
    .waddr  (counter_q),
    .wdata  (in_data),
    .raddr  (sbox_byte_addr(box_sel, {row, col})),
    .rnib   (col[0]),
    .rvalid (rd_valid_s),
    .dout   (dout)
  );

  assign in_ready    = in_ready_q;
  assign load_busy   = load_busy_q;
  assign table_valid = table_valid_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_sbox_table_loader.sv
// Directed bench for sbox_table_loader: loads the standard DES S-boxes and
// checks checksum qualification, stalls, abort/restart and mid-load reset.
module tb_sbox_table_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] box_sel;
  logic [1:0] row;
  logic [3:0] col;
  logic [3:0] dout;
  logic       table_valid;
  logic       load_busy;
  logic       load_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_accepts = 0;
  bit valid_seen   = 1'b0;

  int sbox_tab [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  always #5 clk = ~clk;

  sbox_table_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .box_sel     (box_sel),
    .row         (row),
    .col         (col),
    .dout        (dout),
    .table_valid (table_valid),
    .load_busy   (load_busy),
    .load_err    (load_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tbl_byte(input int k);
    logic [3:0] lo;
    logic [3:0] hi;
    int b;
    int j;
    b  = k / 32;
    j  = k % 32;
    lo = 4'(sbox_tab[b*64 + 2*j]);
    hi = 4'(sbox_tab[b*64 + 2*j + 1]);
    return {hi, lo};
  endfunction

  task automatic pulse_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waitc;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    waitc    = 0;
    while (!in_ready && waitc < 16) begin
      tick();
      waitc++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitc);
    end
    if (load_busy) busy_accepts++;
    if (table_valid) valid_seen = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] csum_flip, input bit gap, input bit do_start);
    logic [7:0] csum;
    logic [7:0] b;
    csum         = 8'h00;
    busy_accepts = 0;
    valid_seen   = 1'b0;
    if (do_start) pulse_start();
    for (int k = 0; k < 256; k++) begin
      b    = tbl_byte(k);
      csum = csum ^ b;
      send_byte(b, gap);
    end
    tests_run++;
    if (valid_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_during_load: table_valid seen=%0b, required 0", valid_seen);
    end
    send_byte(csum ^ csum_flip, gap);
    tests_run++;
    if (busy_accepts !== 257) begin
      tests_failed++;
      $display("FAIL busy_accepts: got %0d, required 257", busy_accepts);
    end
    tests_run++;
    if (load_busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_state: load_busy=%0b in_ready=%0b, required 0 0", load_busy, in_ready);
    end
  endtask

  task automatic check_lookup(input int b, input int r, input int c, input int exp_v);
    box_sel = 3'(b);
    row     = 2'(r);
    col     = 4'(c);
    tick();
    tests_run++;
    if (dout !== 4'(exp_v)) begin
      tests_failed++;
      $display("FAIL lookup b%0d r%0d c%0d: dout=%0d, required %0d", b, r, c, dout, exp_v);
    end
  endtask

  task automatic sweep_all;
    for (int e = 0; e < 512; e++) begin
      check_lookup(e / 64, (e % 64) / 16, e % 16, sbox_tab[e]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    box_sel = 3'd0; row = 2'd0; col = 4'd0;
    tick();
    tick();
    tests_run++;
    if (dout !== 4'd0 || table_valid !== 1'b0 || in_ready !== 1'b0 ||
        load_busy !== 1'b0 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: dout=%0d tv=%0b rdy=%0b busy=%0b err=%0b, required all 0",
               dout, table_valid, in_ready, load_busy, load_err);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || load_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_state: rdy=%0b busy=%0b, required 0 0", in_ready, load_busy);
    end
  endtask

  task automatic test_full_load;
    do_load(8'h00, 1'b0, 1'b1);
    tests_run++;
    if (table_valid !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL good_load_flags: tv=%0b err=%0b, required 1 0", table_valid, load_err);
    end
    check_lookup(0, 0, 0, 14);
    check_lookup(0, 3, 15, 13);
    check_lookup(7, 0, 0, 13);
    sweep_all();
  endtask

  task automatic test_bad_checksum;
    do_load(8'h01, 1'b0, 1'b1);
    tests_run++;
    if (table_valid !== 1'b0 || load_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_csum_flags: tv=%0b err=%0b, required 0 1", table_valid, load_err);
    end
    check_lookup(0, 0, 1, 4);
  endtask

  task automatic test_gaps;
    do_load(8'h00, 1'b1, 1'b1);
    tests_run++;
    if (table_valid !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_load_flags: tv=%0b err=%0b, required 1 0", table_valid, load_err);
    end
    sweep_all();
  endtask

  task automatic test_abort;
    pulse_start();
    for (int k = 0; k < 100; k++) begin
      send_byte(tbl_byte(k), 1'b0);
    end
    tests_run++;
    if (table_valid !== 1'b0 || load_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_mid: tv=%0b busy=%0b, required 0 1", table_valid, load_busy);
    end
    pulse_start();
    tests_run++;
    if (table_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_restart: tv=%0b rdy=%0b, required 0 1", table_valid, in_ready);
    end
    do_load(8'h00, 1'b0, 1'b0);
    tests_run++;
    if (table_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_final_valid: tv=%0b, required 1", table_valid);
    end
    check_lookup(3, 2, 9, 1);
  endtask

  task automatic test_reset_mid_load;
    pulse_start();
    box_sel = 3'd0; row = 2'd0; col = 4'd0;
    send_byte(tbl_byte(0) ^ 8'hFF, 1'b0);
    tests_run++;
    if (dout !== 4'd14) begin
      tests_failed++;
      $display("FAIL read_before_write: dout=%0d, required 14", dout);
    end
    for (int k = 1; k < 40; k++) begin
      send_byte(tbl_byte(k) ^ 8'hFF, 1'b0);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b0 || load_busy !== 1'b0 || table_valid !== 1'b0 ||
        load_err !== 1'b0 || dout !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_load_reset: rdy=%0b busy=%0b tv=%0b err=%0b dout=%0d, required all 0",
               in_ready, load_busy, table_valid, load_err, dout);
    end
    rst = 1'b0;
    check_lookup(0, 0, 0, 1);
    check_lookup(0, 0, 1, 11);
    tests_run++;
    if (table_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: tv=%0b rdy=%0b, required 0 0", table_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_bad_checksum();
    test_gaps();
    test_abort();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
